grf_wb_arbiter: RTL and testbench

Write-back arbiter sharing the single GRF write port (RFWe/Addr/RFWd/PC) among NREQ independent write-back sources (ALU result, load data, multi-cycle mul/div). It grants at most one source per cycle using rotating round-robin priority and registers the winner into an output stage that drives the GRF write port directly. It also exports a pending-write mask for hazard logic and a saturating contention counter for performance monitoring.

---
 rtl/grf_wb_arbiter_if.sv | 25 ++
 rtl/grf_wb_arbiter.sv | 76 +++++++
 tb/tb_grf_wb_arbiter.sv | 137 +++++++++++++
 3 files changed

// File: rtl/grf_wb_arbiter_if.sv
// grf_wb_arbiter_if: write-back request bus and GRF write port.
// master: sources drive wb_hold/req_*; they observe req_ready and the GRF port.
// slave: the arbiter, which produces req_ready, RFWe/Addr/RFWd/PC, pend_mask and conflict_cnt.
interface grf_wb_arbiter_if #(parameter int NREQ = 3);
  logic                 wb_hold;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [5*NREQ-1:0]    req_addr;
  logic [32*NREQ-1:0]   req_data;
  logic [32*NREQ-1:0]   req_pc;
  logic                 RFWe;
  logic [4:0]           Addr;
  logic [31:0]          RFWd;
  logic [31:0]          PC;
  logic [31:0]          pend_mask;
  logic [15:0]          conflict_cnt;
  modport master (
    output wb_hold, req_valid, req_addr, req_data, req_pc,
    input  req_ready, RFWe, Addr, RFWd, PC, pend_mask, conflict_cnt
  );
  modport slave (
    input  wb_hold, req_valid, req_addr, req_data, req_pc,
    output req_ready, RFWe, Addr, RFWd, PC, pend_mask, conflict_cnt
  );
endinterface

// File: rtl/grf_wb_arbiter.sv
// grf_wb_arbiter: round-robin arbiter sharing the single GRF write port among NREQ sources.
// clk: rising-edge clock; reset: asynchronous active-low.
// bus (slave): wb_hold/req_valid/req_addr/req_data/req_pc in; req_ready, registered
// RFWe/Addr/RFWd/PC, pend_mask and saturating conflict_cnt out.
module grf_wb_arbiter #(parameter int NREQ = 3) (
  input logic             clk,
  input logic             reset,
  grf_wb_arbiter_if.slave bus
);
  logic [1:0]  ptr_q, ptr_d, g;
  logic        found, xfer;
  logic        rfwe_q, rfwe_d;
  logic [4:0]  addr_q, addr_d, addr_sel;
  logic [31:0] rfwd_q, rfwd_d, data_sel;
  logic [31:0] pc_q, pc_d, pc_sel;
  logic [15:0] cnt_q, cnt_d;
  // Scan offsets from farthest to nearest so the source closest to ptr wins.
  always_comb begin
    int j;
    g = '0;
    found = 1'b0;
    j = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = int'(ptr_q) + k;
      if (j >= NREQ) j = j - NREQ;
      for (int i = 0; i < NREQ; i++)
        if (i == j && bus.req_valid[i]) begin
          g = 2'(i);
          found = 1'b1;
        end
    end
  end
  always_comb begin
    addr_sel = '0;
    data_sel = '0;
    pc_sel = '0;
    for (int i = 0; i < NREQ; i++)
      if (g == 2'(i)) begin
        addr_sel = bus.req_addr[5*i +: 5];
        data_sel = bus.req_data[32*i +: 32];
        pc_sel = bus.req_pc[32*i +: 32];
      end
  end
  always_comb begin
    xfer = found && !bus.wb_hold;
    rfwe_d = xfer && addr_sel != 5'd0;
    addr_d = xfer ? addr_sel : addr_q;
    rfwd_d = xfer ? data_sel : rfwd_q;
    pc_d = xfer ? pc_sel : pc_q;
    ptr_d = !xfer ? ptr_q : g == 2'(NREQ - 1) ? 2'd0 : g + 2'd1;
    cnt_d = ($countones(bus.req_valid) > 1 && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      ptr_q <= '0;
      rfwe_q <= 1'b0;
      addr_q <= '0;
      rfwd_q <= '0;
      pc_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      rfwe_q <= rfwe_d;
      addr_q <= addr_d;
      rfwd_q <= rfwd_d;
      pc_q <= pc_d;
      cnt_q <= cnt_d;
    end
  assign bus.req_ready = xfer ? NREQ'(1) << g : '0;
  assign bus.RFWe = rfwe_q;
  assign bus.Addr = addr_q;
  assign bus.RFWd = rfwd_q;
  assign bus.PC = pc_q;
  assign bus.pend_mask = rfwe_q ? 32'd1 << addr_q : 32'd0;
  assign bus.conflict_cnt = cnt_q;
endmodule

// File: tb/tb_grf_wb_arbiter.sv
// tb_grf_wb_arbiter: directed bench for grf_wb_arbiter with NREQ=3.
module tb_grf_wb_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int errors = 0;
  int checks = 0;
  logic [31:0] grf [32];
  grf_wb_arbiter_if #(.NREQ(3)) bus ();
  grf_wb_arbiter #(.NREQ(3)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) if (bus.RFWe) grf[bus.Addr] <= bus.RFWd;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic src(input int i, input logic v, input logic [4:0] a, input logic [31:0] d, input logic [31:0] p);
    bus.req_valid[i] = v;
    bus.req_addr[5*i +: 5] = a;
    bus.req_data[32*i +: 32] = d;
    bus.req_pc[32*i +: 32] = p;
  endtask
  initial begin
    bus.wb_hold = 1'b0;
    bus.req_valid = '0;
    bus.req_addr = '0;
    bus.req_data = '0;
    bus.req_pc = '0;
    #2;
    chk("rst_rfwe", bus.RFWe, 0);
    chk("rst_addr", bus.Addr, 0);
    chk("rst_rfwd", bus.RFWd, 0);
    chk("rst_pc", bus.PC, 0);
    chk("rst_pend", bus.pend_mask, 0);
    chk("rst_cnt", bus.conflict_cnt, 0);
    chk("rst_ready", bus.req_ready, 0);
    tick;
    reset = 1'b1;
    // source 1 alone
    src(1, 1'b1, 5'd5, 32'hDEADBEEF, 32'h3000);
    #1 chk("s1_ready", bus.req_ready, 3'b010);
    tick;
    chk("s1_rfwe", bus.RFWe, 1);
    chk("s1_addr", bus.Addr, 5);
    chk("s1_rfwd", bus.RFWd, 32'hDEADBEEF);
    chk("s1_pc", bus.PC, 32'h3000);
    chk("s1_pend", bus.pend_mask, 32'h20);
    src(1, 1'b0, 5'd0, 32'h0, 32'h0);
    // ptr=2: sources 0 and 2 both target $7
    src(0, 1'b1, 5'd7, 32'hAAAA0000, 32'h100);
    src(2, 1'b1, 5'd7, 32'hBBBB0000, 32'h200);
    #1 chk("same_ready_b", bus.req_ready, 3'b100);
    tick;
    chk("same_addr", bus.Addr, 7);
    chk("same_rfwd_b", bus.RFWd, 32'hBBBB0000);
    chk("same_pc_b", bus.PC, 32'h200);
    src(2, 1'b0, 5'd0, 32'h0, 32'h0);
    #1 chk("same_ready_a", bus.req_ready, 3'b001);
    tick;
    chk("same_rfwd_a", bus.RFWd, 32'hAAAA0000);
    chk("same_pc_a", bus.PC, 32'h100);
    chk("same_cnt", bus.conflict_cnt, 1);
    src(0, 1'b0, 5'd0, 32'h0, 32'h0);
    // ptr=1: source 0 writes $0
    src(0, 1'b1, 5'd0, 32'h1234, 32'h400);
    #1 chk("z_ready", bus.req_ready, 3'b001);
    tick;
    chk("z_rfwe", bus.RFWe, 0);
    chk("z_pend", bus.pend_mask, 0);
    chk("grf7", grf[7], 32'hAAAA0000);
    src(0, 1'b0, 5'd0, 32'h0, 32'h0);
    // ptr=1: source 2 alone moves ptr to 0
    src(2, 1'b1, 5'd9, 32'h99, 32'h500);
    #1 chk("s2_ready", bus.req_ready, 3'b100);
    tick;
    chk("s2_addr", bus.Addr, 9);
    src(2, 1'b0, 5'd0, 32'h0, 32'h0);
    // full contention rotates 0,1,2,0,1,2
    for (int i = 0; i < 3; i++) src(i, 1'b1, 5'(i + 1), 32'hA0 + 32'(i), 32'h1000 + 32'(4 * i));
    for (int c = 0; c < 6; c++) begin
      #1 chk("rr_ready", bus.req_ready, 32'd1 << (c % 3));
      tick;
      chk("rr_addr", bus.Addr, 32'((c % 3) + 1));
      chk("rr_rfwd", bus.RFWd, 32'hA0 + 32'(c % 3));
    end
    chk("rr_cnt", bus.conflict_cnt, 7);
    chk("rr_pend", bus.pend_mask, 32'h8);
    // hold with sources 0 and 1 valid
    src(2, 1'b0, 5'd0, 32'h0, 32'h0);
    bus.wb_hold = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1 chk("hold_ready", bus.req_ready, 0);
      tick;
      chk("hold_rfwe", bus.RFWe, 0);
    end
    chk("hold_cnt", bus.conflict_cnt, 10);
    bus.wb_hold = 1'b0;
    #1 chk("rel_ready0", bus.req_ready, 3'b001);
    tick;
    chk("rel_addr0", bus.Addr, 1);
    src(0, 1'b0, 5'd0, 32'h0, 32'h0);
    #1 chk("rel_ready1", bus.req_ready, 3'b010);
    tick;
    chk("rel_addr1", bus.Addr, 2);
    chk("rel_rfwe", bus.RFWe, 1);
    chk("rel_cnt", bus.conflict_cnt, 11);
    src(1, 1'b0, 5'd0, 32'h0, 32'h0);
    // asynchronous reset between edges
    #2 reset = 1'b0;
    #1;
    chk("ar_rfwe", bus.RFWe, 0);
    chk("ar_addr", bus.Addr, 0);
    chk("ar_rfwd", bus.RFWd, 0);
    chk("ar_pend", bus.pend_mask, 0);
    chk("ar_cnt", bus.conflict_cnt, 0);
    tick;
    reset = 1'b1;
    // saturation under held contention
    bus.wb_hold = 1'b1;
    for (int i = 0; i < 3; i++) src(i, 1'b1, 5'(i + 1), 32'h0, 32'h0);
    repeat (65534) @(posedge clk);
    #1 chk("sat_fffe", bus.conflict_cnt, 16'hFFFE);
    chk("sat_ready", bus.req_ready, 0);
    tick;
    chk("sat_ffff", bus.conflict_cnt, 16'hFFFF);
    tick;
    chk("sat_hold", bus.conflict_cnt, 16'hFFFF);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
